halut_result_buffer: RTL and testbench

Downstream of the multi-unit decoder stage. Captures its FP32 result stream (result, valid, m_addr) into a small FIFO and re-emits it on a valid/ready interface toward writeback, because the decoder has no backpressure. Tags the last result of each decoder burst. Flags dropped results (overflow) and out-of-order m_addr (sequence error) with sticky flags.

---
 rtl/halut_pkg.sv | 15 +
 rtl/halut_sync_fifo.sv | 71 +++++++
 rtl/halut_result_buffer.sv | 125 ++++++++++++
 tb/tb_halut_result_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/halut_pkg.sv
// Shared constants and types for the HALUT datapath.
// Holds the decoder-unit count, result buffer depth and the buffered result entry layout.
package halut_pkg;

    localparam int DecoderUnits      = 4;
    localparam int DecAddrWidth      = $clog2(DecoderUnits);
    localparam int ResultBufferDepth = 16;

    typedef struct packed {
        logic [31:0]             result;
        logic [DecAddrWidth-1:0] m_addr;
        logic                    last;
    } result_entry_t;

endpackage

// File: rtl/halut_sync_fifo.sv
// Single-clock FIFO with occupancy count, synchronous flush and asynchronous active-low reset.
// Head entry is read combinationally at the read pointer; pointers wrap at Depth (power of two).
module halut_sync_fifo #(
    parameter int  Depth   = 16,
    parameter type entry_t = logic [7:0],
    localparam int PtrWidth = $clog2(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  entry_t            wdata_i,
    output entry_t            rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [PtrWidth:0] fill_o
);

    entry_t              r_mem [Depth];
    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic [PtrWidth:0]   r_fill;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_fill == (PtrWidth+1)'(Depth));
    assign w_empty = (r_fill == '0);
    assign w_pop   = pop_i && !w_empty && !flush_i;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_push  = push_i && !flush_i && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (PtrWidth+1)'(1);
                2'b01:   r_fill <= r_fill - (PtrWidth+1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign rdata_o = r_mem[r_rd_ptr];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign fill_o  = r_fill;

endmodule

// File: rtl/halut_result_buffer.sv
// Buffers the decoder result stream (which cannot stall) and re-emits it on valid/ready.
// Optional saturating stats counters are built when HALUT_RESULT_BUFFER_STATS_EN is defined.
module halut_result_buffer #(
    parameter int DecoderUnits = halut_pkg::DecoderUnits,
    parameter int Depth        = halut_pkg::ResultBufferDepth,
    parameter int DecAddrWidth = $clog2(DecoderUnits),
    parameter int PtrWidth     = $clog2(Depth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [31:0]             result_i,
    input  logic                    valid_i,
    input  logic [DecAddrWidth-1:0] m_addr_i,
    output logic [31:0]             out_data_o,
    output logic [DecAddrWidth-1:0] out_m_addr_o,
    output logic                    out_last_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    input  logic                    flush_i,
    input  logic                    clear_flags_i,
    output logic [PtrWidth:0]       fill_o,
    output logic                    overflow_o,
    output logic                    seq_err_o,
    output logic [31:0]             accepted_cnt_o,
    output logic [31:0]             dropped_cnt_o
);

    import halut_pkg::*;

    localparam logic [DecAddrWidth-1:0] LastAddr = DecAddrWidth'(DecoderUnits - 1);

    result_entry_t           w_entry_in;
    result_entry_t           w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_out_valid;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_seq_bad;
    logic [DecAddrWidth-1:0] w_next_addr;

    logic [DecAddrWidth-1:0] r_exp_addr;
    logic                    r_overflow;
    logic                    r_seq_err;

    assign w_entry_in.result = result_i;
    assign w_entry_in.m_addr = m_addr_i;
    assign w_entry_in.last   = (m_addr_i == LastAddr);

    assign w_out_valid = !w_empty;
    assign w_pop       = w_out_valid && out_ready_i;
    assign w_push      = valid_i && !flush_i && (!w_full || w_pop);
    assign w_drop      = valid_i && !flush_i && w_full && !w_pop;

    halut_sync_fifo #(
        .Depth   (Depth),
        .entry_t (result_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_entry_in),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .fill_o  (fill_o)
    );

    // The tracker follows every incoming result, stored or dropped, so it resyncs after an error.
    assign w_seq_bad   = valid_i && !flush_i && (m_addr_i != r_exp_addr);
    assign w_next_addr = (m_addr_i == LastAddr) ? '0 : m_addr_i + DecAddrWidth'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_exp_addr <= '0;
            r_overflow <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            if (flush_i) begin
                r_exp_addr <= '0;
            end else if (valid_i) begin
                r_exp_addr <= w_next_addr;
            end
            r_overflow <= w_drop    | (r_overflow & ~clear_flags_i);
            r_seq_err  <= w_seq_bad | (r_seq_err  & ~clear_flags_i);
        end
    end

`ifdef HALUT_RESULT_BUFFER_STATS_EN
    logic [31:0] r_accepted_cnt;
    logic [31:0] r_dropped_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_accepted_cnt <= '0;
            r_dropped_cnt  <= '0;
        end else begin
            if (w_push && (r_accepted_cnt != '1)) begin
                r_accepted_cnt <= r_accepted_cnt + 32'd1;
            end
            if (w_drop && (r_dropped_cnt != '1)) begin
                r_dropped_cnt <= r_dropped_cnt + 32'd1;
            end
        end
    end

    assign accepted_cnt_o = r_accepted_cnt;
    assign dropped_cnt_o  = r_dropped_cnt;
`else
    assign accepted_cnt_o = '0;
    assign dropped_cnt_o  = '0;
`endif

    // Storage is uninitialised after reset, so head fields are masked while empty.
    assign out_valid_o  = w_out_valid;
    assign out_data_o   = w_out_valid ? w_head.result : '0;
    assign out_m_addr_o = w_out_valid ? w_head.m_addr : '0;
    assign out_last_o   = w_out_valid && w_head.last;
    assign overflow_o   = r_overflow;
    assign seq_err_o    = r_seq_err;

endmodule

// File: tb/tb_halut_result_buffer.sv
// Self-checking bench for halut_result_buffer (DecoderUnits=4, Depth=16) with a queue scoreboard.
module tb_halut_result_buffer;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] result_i;
    logic        valid_i;
    logic [1:0]  m_addr_i;
    logic [31:0] out_data_o;
    logic [1:0]  out_m_addr_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        flush_i;
    logic        clear_flags_i;
    logic [4:0]  fill_o;
    logic        overflow_o;
    logic        seq_err_o;
    logic [31:0] accepted_cnt_o;
    logic [31:0] dropped_cnt_o;

    halut_result_buffer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .result_i       (result_i),
        .valid_i        (valid_i),
        .m_addr_i       (m_addr_i),
        .out_data_o     (out_data_o),
        .out_m_addr_o   (out_m_addr_o),
        .out_last_o     (out_last_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .flush_i        (flush_i),
        .clear_flags_i  (clear_flags_i),
        .fill_o         (fill_o),
        .overflow_o     (overflow_o),
        .seq_err_o      (seq_err_o),
        .accepted_cnt_o (accepted_cnt_o),
        .dropped_cnt_o  (dropped_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  a;
        logic        l;
    } ent_t;

    typedef struct {
        logic        v;
        logic [1:0]  a;
        logic [31:0] d;
        logic        rdy;
        logic        clr;
        int          fill;
        logic        seq;
    } vec_t;

    ent_t        q[$];
    vec_t        tbl[12];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  m_exp = 2'd0;
    logic        m_ovf = 1'b0;
    logic        m_seq = 1'b0;
    int unsigned m_acc = 0;
    int unsigned m_drop = 0;
    logic [1:0]  addr_v;

    function automatic logic [31:0] cnt_exp(input int unsigned v);
`ifdef HALUT_RESULT_BUFFER_STATS_EN
        return v;
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle from a negedge, checks the head against the scoreboard,
    // advances the model, then checks the registered state at the next negedge.
    task automatic cycle(input logic v, input logic [1:0] a, input logic [31:0] d,
                         input logic rdy, input logic fl, input logic clr);
        logic pop;
        logic full;
        logic set_o;
        logic set_s;
        valid_i       = v;
        m_addr_i      = a;
        result_i      = d;
        out_ready_i   = rdy;
        flush_i       = fl;
        clear_flags_i = clr;
        #1;
        chk("out_valid", {31'd0, out_valid_o}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("head_data", out_data_o, q[0].d);
            chk("head_addr", {30'd0, out_m_addr_o}, {30'd0, q[0].a});
            chk("head_last", {31'd0, out_last_o}, {31'd0, q[0].l});
        end else begin
            chk("empty_data", out_data_o, 32'd0);
        end
        pop   = (q.size() != 0) && rdy;
        full  = (q.size() == DEPTH);
        set_o = 1'b0;
        set_s = 1'b0;
        if (fl) begin
            q.delete();
            m_exp = 2'd0;
        end else begin
            if (pop) void'(q.pop_front());
            if (v) begin
                if (!full || pop) begin
                    q.push_back('{d, a, (a == 2'd3)});
                    m_acc++;
                end else begin
                    set_o = 1'b1;
                    m_drop++;
                end
                if (a != m_exp) set_s = 1'b1;
                m_exp = a + 2'd1;
            end
        end
        m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_seq = set_s ? 1'b1 : (clr ? 1'b0 : m_seq);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("fill", {27'd0, fill_o}, q.size());
        chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
        chk("seq_err", {31'd0, seq_err_o}, {31'd0, m_seq});
        chk("accepted_cnt", accepted_cnt_o, cnt_exp(m_acc));
        chk("dropped_cnt", dropped_cnt_o, cnt_exp(m_drop));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
        chk({tag, "_data"}, out_data_o, 32'd0);
        chk({tag, "_addr"}, {30'd0, out_m_addr_o}, 32'd0);
        chk({tag, "_last"}, {31'd0, out_last_o}, 32'd0);
        chk({tag, "_fill"}, {27'd0, fill_o}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow_o}, 32'd0);
        chk({tag, "_seq"}, {31'd0, seq_err_o}, 32'd0);
        chk({tag, "_acc"}, accepted_cnt_o, 32'd0);
        chk({tag, "_drop"}, dropped_cnt_o, 32'd0);
    endtask

    initial begin
        // Burst 0..3 with ready high, then the out-of-order / resync / clear sequence.
        tbl[0]  = '{1'b1, 2'd0, 32'h3F80_0000, 1'b1, 1'b0, 1, 1'b0};
        tbl[1]  = '{1'b1, 2'd1, 32'h4000_0000, 1'b1, 1'b0, 1, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 32'h4040_0000, 1'b1, 1'b0, 1, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 32'h4080_0000, 1'b1, 1'b0, 1, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 32'h0000_00A0, 1'b1, 1'b0, 1, 1'b0};
        tbl[6]  = '{1'b1, 2'd1, 32'h0000_00A1, 1'b1, 1'b0, 1, 1'b0};
        tbl[7]  = '{1'b1, 2'd0, 32'h0000_00A2, 1'b1, 1'b0, 1, 1'b1};
        tbl[8]  = '{1'b1, 2'd1, 32'h0000_00A3, 1'b1, 1'b0, 1, 1'b1};
        tbl[9]  = '{1'b1, 2'd2, 32'h0000_00A4, 1'b1, 1'b0, 1, 1'b1};
        tbl[10] = '{1'b1, 2'd3, 32'h0000_00A5, 1'b1, 1'b0, 1, 1'b1};
        tbl[11] = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0};

        rst_ni = 1'b0; valid_i = 1'b0; m_addr_i = 2'd0; result_i = 32'd0;
        out_ready_i = 1'b0; flush_i = 1'b0; clear_flags_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("reset");
        rst_ni = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].rdy, 1'b0, tbl[i].clr);
            chk($sformatf("tbl%0d_fill", i), {27'd0, fill_o}, tbl[i].fill);
            chk($sformatf("tbl%0d_seq", i), {31'd0, seq_err_o}, {31'd0, tbl[i].seq});
        end

        // Overflow: 17 pushes with the consumer stalled.
        for (int i = 0; i < 17; i++) begin
            addr_v = 2'(i);
            cycle(1'b1, addr_v, 32'h0000_1000 + i, 1'b0, 1'b0, 1'b0);
        end
        chk("ovf_fill", {27'd0, fill_o}, 32'd16);
        chk("ovf_flag", {31'd0, overflow_o}, 32'd1);
        chk("ovf_dropped", dropped_cnt_o, cnt_exp(1));

        // Full with simultaneous push and pop keeps the count and raises no overflow.
        cycle(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, m_exp, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
        chk("fullpp_fill", {27'd0, fill_o}, 32'd16);
        chk("fullpp_ovf", {31'd0, overflow_o}, 32'd0);
        for (int i = 0; i < 18; i++) cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("drain_fill", {27'd0, fill_o}, 32'd0);

        // Flush with a same-cycle valid input.
        for (int i = 0; i < 5; i++) cycle(1'b1, m_exp, 32'h0000_3000 + i, 1'b0, 1'b0, 1'b0);
        chk("preflush_fill", {27'd0, fill_o}, 32'd5);
        cycle(1'b1, 2'd2, 32'h0000_DEAD, 1'b0, 1'b1, 1'b0);
        chk("flush_fill", {27'd0, fill_o}, 32'd0);
        chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
        cycle(1'b1, 2'd0, 32'h0000_3100, 1'b1, 1'b0, 1'b0);
        chk("postflush_seq", {31'd0, seq_err_o}, 32'd0);
        cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-stream with 7 entries and a sequence error pending.
        for (int i = 0; i < 7; i++) begin
            addr_v = (i == 3) ? m_exp + 2'd1 : m_exp;
            cycle(1'b1, addr_v, 32'h0000_4100 + i, 1'b0, 1'b0, 1'b0);
        end
        chk("prerst_fill", {27'd0, fill_o}, 32'd7);
        chk("prerst_seq", {31'd0, seq_err_o}, 32'd1);
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check_all_zero("async_rst");
        q.delete(); m_exp = 2'd0; m_ovf = 1'b0; m_seq = 1'b0; m_acc = 0; m_drop = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(1'b1, 2'd0, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
        chk("rst_lat_valid", {31'd0, out_valid_o}, 32'd1);
        chk("rst_lat_data", out_data_o, 32'h0000_4000);
        cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
